counter_checker: RTL and testbench
==================================

// Module: counter_checker
// PURPOSE
//  Passive observer on the counter interface (clk, rst_n, load, en, up_dn, data_in, count).
//  Keeps a cycle-accurate model of the counter and compares it with the DUT's count every cycle.
//  Reports mismatches through a sticky flag and a saturating error counter.
//  Instantiated in top next to the counter; it only reads the interface and never drives it.
// PARAMETERS
//  WIDTH       8    counter data width (data_in, count, model register)
//  ERR_W       8    width of the saturating error counter
//  HALT_ON_ERR 0    1: stop checking after the first mismatch (FAULT state); 0: keep checking
// PORTS
//  clk        in   1      interface clock, rising edge
//  rst_n      in   1      asynchronous reset, active-low
//  chk_en     in   1      enables checking; 0 holds the checker in IDLE
//  load       in   1      counter load strobe (sampled)
//  en         in   1      counter count enable (sampled)
//  up_dn      in   1      1 = count up, 0 = count down (sampled)
//  data_in    in   WIDTH  counter load value (sampled)
//  count      in   WIDTH  counter output under check
//  exp_count  out  WIDTH  model's expected count for the current cycle
//  mismatch   out  1      1-cycle pulse: count != exp_count while in CHECK
//  err_sticky out  1      set on the first mismatch, cleared only by reset
//  err_cnt    out  ERR_W  number of mismatches, saturates at all-ones
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, exp_count=0, mismatch=0, err_sticky=0, err_cnt=0.
//  Counter model, per rising edge with priority load > en:
//   load=1 -> next = data_in.
//   en=1   -> next = count +/-1 (mod 2^WIDTH): all-ones+1 -> 0; 0-1 -> all-ones.
//   else   -> next = current value (hold).
//  The model register updates every edge in every state except FAULT, so it tracks the DUT continuously.
//  The counter is registered: inputs sampled at edge N produce count at edge N+1. The compare is on
//   the registered exp_count against the live count, evaluated combinationally and registered into mismatch.
//   mismatch therefore asserts one cycle after the bad count is visible.
//  FSM:
//   IDLE : mismatch held 0. If chk_en=1 -> SYNC.
//   SYNC : exp_count <= next computed from the DUT's own count, which resynchronises the model.
//          No compare in this state. Next edge -> CHECK.
//   CHECK: compare every cycle. On mismatch: pulse mismatch, set err_sticky, err_cnt+1 (saturating).
//          Also resync the model from count so one fault is reported once, not on every later cycle.
//          chk_en=0 -> IDLE. If HALT_ON_ERR=1, a mismatch -> FAULT.
//   FAULT: outputs frozen, mismatch=0; exit only via reset.
//  load and en in the same cycle: load wins and en is ignored.
//  chk_en dropped and raised again: passes through SYNC again, so no false error after a gap.
//  rst_n asserted in any state: immediate return to reset values, including from FAULT.
//  X or Z on count in CHECK counts as a mismatch (!== compare in simulation).
// CONFIGURATION
//  CNT_CHK_COVER_EN defined: adds outputs wrap_up_cnt[ERR_W] and wrap_dn_cnt[ERR_W], both saturating.
//   wrap_up_cnt counts model transitions all-ones->0 on up-count; wrap_dn_cnt counts 0->all-ones on down-count.
//   Both counters update in CHECK only and reset to 0.
//  CNT_CHK_COVER_EN undefined: neither port nor their logic exists; all other behaviour is identical.
// TESTING
//  1) Reset, chk_en=1, en=1, up_dn=1 for 20 cycles, correct counter -> mismatch never 1; err_cnt=0.
//  2) load=1, data_in=8'hFE, then en=1 for 3 up cycles -> exp_count FE,FF,00,01; no error;
//     with CNT_CHK_COVER_EN, wrap_up_cnt=1.
//  3) load=1 with en=1, data_in=8'h10 -> exp_count=8'h10 (load priority); no error.
//  4) Force count=8'h55 for one cycle when 8'h05 is expected -> exactly one mismatch pulse; err_sticky=1;
//     err_cnt=1; checking resumes error-free.
//  5) HALT_ON_ERR=1, inject an error -> FAULT; later errors leave err_cnt=1; rst_n=0 mid-run clears all outputs.
//  6) chk_en=0 for 5 cycles while the counter loads 8'h80, then chk_en=1 -> SYNC then CHECK; no mismatch.

Source files
------------

// File: rtl/counter_checker.sv
// -----------------------------------------------------------------------------
// counter_checker
//
// Passive checker that sits next to an up/down counter with load. It only
// reads the counter interface and never drives it. It keeps a cycle-accurate
// model of the counter and compares that model with the counter's count on
// every cycle.
//
// Once checking is enabled, the checker first resynchronises its model from
// the live count (SYNC). It then compares every cycle (CHECK). When a
// mismatch is found it is reported once, and the model is realigned to the
// count it observed.
//
// Parameters
//   WIDTH        counter data width
//   ERR_W        width of the saturating error (and coverage) counters
//   HALT_ON_ERR  1: freeze in FAULT after the first mismatch; 0: keep going
//
// Optional feature (macro CNT_CHK_COVER_EN):
//   adds wrap_up_cnt / wrap_dn_cnt, which are saturating counts of model
//   wraps (all-ones -> 0 counting up, 0 -> all-ones counting down), taken in
//   CHECK only.
//
// Ports
//   clk         in   interface clock, rising edge
//   rst_n       in   asynchronous reset, active-low
//   chk_en      in   enables checking; 0 returns the checker to IDLE
//   load        in   counter load strobe (has priority over en)
//   en          in   counter count enable
//   up_dn       in   1 = count up, 0 = count down
//   data_in     in   counter load value
//   count       in   counter output under check
//   exp_count   out  model's expected count for the current cycle
//   mismatch    out  one-cycle pulse, registered compare result in CHECK
//   err_sticky  out  set on first mismatch, cleared only by reset
//   err_cnt     out  number of mismatches, saturates at all-ones
//   wrap_up_cnt out  (CNT_CHK_COVER_EN only) up-count wrap events
//   wrap_dn_cnt out  (CNT_CHK_COVER_EN only) down-count wrap events
// -----------------------------------------------------------------------------
module counter_checker #(
  parameter int WIDTH       = 8,
  parameter int ERR_W       = 8,
  parameter int HALT_ON_ERR = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             chk_en,
  input  logic             load,
  input  logic             en,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] exp_count,
  output logic             mismatch,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_cnt
`ifdef CNT_CHK_COVER_EN
  ,
  output logic [ERR_W-1:0] wrap_up_cnt,
  output logic [ERR_W-1:0] wrap_dn_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    CHECK = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t state;

  // Saturating increment shared by the error and coverage counters.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    sat_inc = (&v) ? v : v + ERR_W'(1);
  endfunction

  // One step of the counter: load beats en, and +/-1 wraps modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] model_next(
    input logic [WIDTH-1:0] base,
    input logic             ld,
    input logic             inc_en,
    input logic             up,
    input logic [WIDTH-1:0] ld_val
  );
    if (ld)
      model_next = ld_val;
    else if (inc_en)
      model_next = up ? base + WIDTH'(1) : base - WIDTH'(1);
    else
      model_next = base;
  endfunction

  logic             diff_p0;
  logic             cmp_fail_p0;
  logic             resync_p0;
  logic [WIDTH-1:0] base_p0;
  logic [WIDTH-1:0] next_p0;
`ifdef CNT_CHK_COVER_EN
  logic             wrap_up_p0;
  logic             wrap_dn_p0;
`endif

  // ---- stage p0: compare registered model with live count, form next model
  always_comb begin
    diff_p0     = 1'b0;
    cmp_fail_p0 = 1'b0;
    resync_p0   = 1'b0;
    base_p0     = exp_count;
    next_p0     = exp_count;
    // Case inequality so an X/Z count is flagged in simulation.
    diff_p0     = (count !== exp_count);
    cmp_fail_p0 = (state == CHECK) && diff_p0;
    // In SYNC, or after a detected fault, continue from what the counter
    // really shows, so that a single fault is reported exactly once.
    resync_p0   = (state == SYNC) || cmp_fail_p0;
    base_p0     = resync_p0 ? count : exp_count;
    next_p0     = model_next(base_p0, load, en, up_dn, data_in);
  end

`ifdef CNT_CHK_COVER_EN
  always_comb begin
    wrap_up_p0 = 1'b0;
    wrap_dn_p0 = 1'b0;
    wrap_up_p0 = !load && en &&  up_dn && (&base_p0);
    wrap_dn_p0 = !load && en && !up_dn && (base_p0 == '0);
  end
`endif

  // ---- stage p1: FSM, model register and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      exp_count  <= '0;
      mismatch   <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
`ifdef CNT_CHK_COVER_EN
      wrap_up_cnt <= '0;
      wrap_dn_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          mismatch  <= 1'b0;
          exp_count <= next_p0;
          if (chk_en)
            state <= SYNC;
        end
        SYNC: begin
          mismatch  <= 1'b0;
          exp_count <= next_p0;
          state     <= CHECK;
        end
        CHECK: begin
          mismatch  <= cmp_fail_p0;
          exp_count <= next_p0;
          if (cmp_fail_p0) begin
            err_sticky <= 1'b1;
            err_cnt    <= sat_inc(err_cnt);
          end
`ifdef CNT_CHK_COVER_EN
          if (wrap_up_p0)
            wrap_up_cnt <= sat_inc(wrap_up_cnt);
          if (wrap_dn_p0)
            wrap_dn_cnt <= sat_inc(wrap_dn_cnt);
`endif
          if ((HALT_ON_ERR != 0) && cmp_fail_p0)
            state <= FAULT;
          else if (!chk_en)
            state <= IDLE;
        end
        FAULT: begin
          // Frozen until reset; only the pulse output is forced low.
          mismatch <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          mismatch <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_checker.sv
// -----------------------------------------------------------------------------
// tb_counter_checker
//
// The bench plays the counter itself. It has a register counter driven by
// load/en/up_dn/data_in, plus a "corrupt" hook that silently overwrites the
// counter register to imitate a faulty counter.
//
// Two checkers watch the same interface: one with HALT_ON_ERR=0 and one
// with HALT_ON_ERR=1.
//
// Before each clock edge, the expected outputs of the first checker are
// pushed into a scoreboard queue. One time unit after the edge they are
// popped and compared.
// -----------------------------------------------------------------------------
module tb_counter_checker;

  logic       clk;
  logic       rst_n;
  logic       chk_en;
  logic       load;
  logic       en;
  logic       up_dn;
  logic [7:0] data_in;
  logic [7:0] count;
  logic [7:0] cnt_q;
  logic       corrupt;
  logic [7:0] corrupt_val;

  logic [7:0] exp_count;
  logic       mismatch;
  logic       err_sticky;
  logic [7:0] err_cnt;
  logic [7:0] h_exp_count;
  logic       h_mismatch;
  logic       h_err_sticky;
  logic [7:0] h_err_cnt;
`ifdef CNT_CHK_COVER_EN
  logic [7:0] wrap_up_cnt;
  logic [7:0] wrap_dn_cnt;
  logic [7:0] h_wrap_up_cnt;
  logic [7:0] h_wrap_dn_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string      tag;
    logic [7:0] e_val;
    logic       e_mm;
    logic       e_st;
    logic [7:0] e_ec;
  } exp_t;

  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter standing in for the design under observation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= 8'h00;
    else if (corrupt)
      cnt_q <= corrupt_val;
    else if (load)
      cnt_q <= data_in;
    else if (en)
      cnt_q <= up_dn ? cnt_q + 8'd1 : cnt_q - 8'd1;
  end

  assign count = cnt_q;

  counter_checker #(.WIDTH(8), .ERR_W(8), .HALT_ON_ERR(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .chk_en     (chk_en),
    .load       (load),
    .en         (en),
    .up_dn      (up_dn),
    .data_in    (data_in),
    .count      (count),
    .exp_count  (exp_count),
    .mismatch   (mismatch),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt)
`ifdef CNT_CHK_COVER_EN
    ,
    .wrap_up_cnt(wrap_up_cnt),
    .wrap_dn_cnt(wrap_dn_cnt)
`endif
  );

  counter_checker #(.WIDTH(8), .ERR_W(8), .HALT_ON_ERR(1)) dut_h (
    .clk        (clk),
    .rst_n      (rst_n),
    .chk_en     (chk_en),
    .load       (load),
    .en         (en),
    .up_dn      (up_dn),
    .data_in    (data_in),
    .count      (count),
    .exp_count  (h_exp_count),
    .mismatch   (h_mismatch),
    .err_sticky (h_err_sticky),
    .err_cnt    (h_err_cnt)
`ifdef CNT_CHK_COVER_EN
    ,
    .wrap_up_cnt(h_wrap_up_cnt),
    .wrap_dn_cnt(h_wrap_dn_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: queue the expectation, let the edge happen, then pop and compare.
  task automatic cyc(input string tag, input logic [7:0] e_val, input logic e_mm,
                     input logic e_st, input logic [7:0] e_ec);
    exp_t e;
    e.tag   = tag;
    e.e_val = e_val;
    e.e_mm  = e_mm;
    e.e_st  = e_st;
    e.e_ec  = e_ec;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".exp_count"},  exp_count,      e.e_val);
    chk({e.tag, ".mismatch"},   8'(mismatch),   8'(e.e_mm));
    chk({e.tag, ".err_sticky"}, 8'(err_sticky), 8'(e.e_st));
    chk({e.tag, ".err_cnt"},    err_cnt,        e.e_ec);
  endtask

  initial begin
    rst_n       = 1'b0;
    chk_en      = 1'b0;
    load        = 1'b0;
    en          = 1'b0;
    up_dn       = 1'b1;
    data_in     = 8'h00;
    corrupt     = 1'b0;
    corrupt_val = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.exp_count",  exp_count,      8'h00);
    chk("rst.mismatch",   8'(mismatch),   8'h00);
    chk("rst.err_sticky", 8'(err_sticky), 8'h00);
    chk("rst.err_cnt",    err_cnt,        8'h00);
    chk("rst.h_err_cnt",  h_err_cnt,      8'h00);
    rst_n = 1'b1;

    // 1) 20 cycles of correct up-counting
    chk_en = 1'b1;
    en     = 1'b1;
    up_dn  = 1'b1;
    for (int i = 1; i <= 20; i++)
      cyc("t1", 8'(i), 1'b0, 1'b0, 8'h00);

    // 2) Load FE, then count up across the wrap
    load    = 1'b1;
    en      = 1'b0;
    data_in = 8'hFE;
    cyc("t2.load", 8'hFE, 1'b0, 1'b0, 8'h00);
    load = 1'b0;
    en   = 1'b1;
    cyc("t2.up1", 8'hFF, 1'b0, 1'b0, 8'h00);
    cyc("t2.up2", 8'h00, 1'b0, 1'b0, 8'h00);
    cyc("t2.up3", 8'h01, 1'b0, 1'b0, 8'h00);

    // Down-count across zero
    load    = 1'b1;
    en      = 1'b0;
    data_in = 8'h01;
    cyc("t2b.load", 8'h01, 1'b0, 1'b0, 8'h00);
    load  = 1'b0;
    en    = 1'b1;
    up_dn = 1'b0;
    cyc("t2b.dn1", 8'h00, 1'b0, 1'b0, 8'h00);
    cyc("t2b.dn2", 8'hFF, 1'b0, 1'b0, 8'h00);
    cyc("t2b.dn3", 8'hFE, 1'b0, 1'b0, 8'h00);
`ifdef CNT_CHK_COVER_EN
    chk("cov.wrap_up", wrap_up_cnt, 8'h01);
    chk("cov.wrap_dn", wrap_dn_cnt, 8'h01);
`endif
    up_dn = 1'b1;

    // 3) load and en together: load wins
    load    = 1'b1;
    en      = 1'b1;
    data_in = 8'h10;
    cyc("t3.load_en", 8'h10, 1'b0, 1'b0, 8'h00);
    load = 1'b0;
    en   = 1'b0;
    cyc("t3.hold", 8'h10, 1'b0, 1'b0, 8'h00);

    // 4) Counter jumps to 55 while 05 is expected
    load    = 1'b1;
    data_in = 8'h04;
    cyc("t4.load", 8'h04, 1'b0, 1'b0, 8'h00);
    load = 1'b0;
    en   = 1'b1;
    cyc("t4.up", 8'h05, 1'b0, 1'b0, 8'h00);
    en          = 1'b0;
    corrupt     = 1'b1;
    corrupt_val = 8'h55;
    cyc("t4.inject", 8'h05, 1'b0, 1'b0, 8'h00);
    corrupt = 1'b0;
    cyc("t4.hit", 8'h55, 1'b1, 1'b1, 8'h01);
    chk("t4.h_mismatch", 8'(h_mismatch), 8'h01);
    chk("t4.h_err_cnt",  h_err_cnt,      8'h01);
    cyc("t4.after", 8'h55, 1'b0, 1'b1, 8'h01);
    chk("t4.h_pulse_end", 8'(h_mismatch), 8'h00);
    en = 1'b1;
    cyc("t4.run1", 8'h56, 1'b0, 1'b1, 8'h01);
    cyc("t4.run2", 8'h57, 1'b0, 1'b1, 8'h01);
    cyc("t4.run3", 8'h58, 1'b0, 1'b1, 8'h01);
    chk("t4.h_frozen_exp", h_exp_count, 8'h55);

    // 5) Second fault: non-halting checker counts it, halted one stays frozen
    en          = 1'b0;
    corrupt     = 1'b1;
    corrupt_val = 8'h00;
    cyc("t5.inject", 8'h58, 1'b0, 1'b1, 8'h01);
    corrupt = 1'b0;
    cyc("t5.hit", 8'h00, 1'b1, 1'b1, 8'h02);
    chk("t5.h_err_cnt",    h_err_cnt,        8'h01);
    chk("t5.h_mismatch",   8'(h_mismatch),   8'h00);
    chk("t5.h_err_sticky", 8'(h_err_sticky), 8'h01);
    chk("t5.h_exp_count",  h_exp_count,      8'h55);
    // Asynchronous reset in the middle of a cycle
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5.rst.err_cnt",    err_cnt,          8'h00);
    chk("t5.rst.err_sticky", 8'(err_sticky),   8'h00);
    chk("t5.rst.mismatch",   8'(mismatch),     8'h00);
    chk("t5.rst.h_err_cnt",  h_err_cnt,        8'h00);
    chk("t5.rst.h_sticky",   8'(h_err_sticky), 8'h00);
    chk("t5.rst.h_exp",      h_exp_count,      8'h00);
    chk_en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 6) Checking off while the counter loads 80 and then silently moves to 90
    load    = 1'b1;
    data_in = 8'h80;
    cyc("t6.load", 8'h80, 1'b0, 1'b0, 8'h00);
    load        = 1'b0;
    corrupt     = 1'b1;
    corrupt_val = 8'h90;
    cyc("t6.idle1", 8'h80, 1'b0, 1'b0, 8'h00);
    corrupt = 1'b0;
    cyc("t6.idle2", 8'h80, 1'b0, 1'b0, 8'h00);
    cyc("t6.idle3", 8'h80, 1'b0, 1'b0, 8'h00);
    cyc("t6.idle4", 8'h80, 1'b0, 1'b0, 8'h00);
    chk_en = 1'b1;
    en     = 1'b1;
    up_dn  = 1'b1;
    cyc("t6.to_sync",  8'h81, 1'b0, 1'b0, 8'h00);
    cyc("t6.sync",     8'h92, 1'b0, 1'b0, 8'h00);
    cyc("t6.check1",   8'h93, 1'b0, 1'b0, 8'h00);
    cyc("t6.check2",   8'h94, 1'b0, 1'b0, 8'h00);
    cyc("t6.check3",   8'h95, 1'b0, 1'b0, 8'h00);
    chk("t6.h_exp",      h_exp_count,    8'h95);
    chk("t6.h_err_cnt",  h_err_cnt,      8'h00);
    chk("t6.h_mismatch", 8'(h_mismatch), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
